// File: rtl/match_result_collector.sv
// match_result_collector
// Collects the two per-cycle classification results of the priority solver
// into a dual-write, single-read FIFO and presents them one at a time on a
// valid/ready interface. Also keeps saturating hit/miss/drop statistics.
// The lookup side never stalls: results that find no room are dropped and
// counted, lane 1 taking precedence over lane 2 for the last free slot.

module match_result_collector #(
    parameter int RULE_ID   = 14,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic [RULE_ID-1:0]       rule_id1,
    input  logic [RULE_ID-1:0]       rule_id2,
    input  logic                     data_valid_in1,
    input  logic                     data_valid_in2,
    input  logic                     action_valid_in1,
    input  logic                     action_valid_in2,
    output logic [RULE_ID-1:0]       out_rule_id,
    output logic                     out_hit,
    output logic                     out_lane,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow_sticky,
    input  logic                     clr_stats,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count,
    output logic [CNT_WIDTH-1:0]     drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = RULE_ID + 2;   // {lane, hit, rule_id}

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic [CW-1:0]  free_slots;
    logic           acc1;
    logic           acc2;
    logic [AW-1:0]  wr_addr2;
    logic [1:0]     n_accepted;
    logic [1:0]     n_drops;
    logic [1:0]     n_hits;
    logic [1:0]     n_misses;
    logic           pop;
    logic [EW-1:0]  head;

    // Saturating add of a 0..2 increment; the counter sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [1:0]           inc
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // Admission: free space is taken from the registered count, so a pop in
    // the same cycle never makes room for a push. Lane 1 is served first.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        free_slots = CW'(DEPTH) - fifo_count;
        acc1       = data_valid_in1 && (free_slots != '0);
        acc2       = 1'b0;
        if (data_valid_in2) begin
            acc2 = data_valid_in1 ? (free_slots >= CW'(2)) : (free_slots != '0);
        end
        wr_addr2   = wr_ptr + AW'(acc1);
        n_accepted = {1'b0, acc1} + {1'b0, acc2};
        n_drops    = {1'b0, data_valid_in1 & ~acc1} + {1'b0, data_valid_in2 & ~acc2};
        n_hits     = {1'b0, data_valid_in1 &  action_valid_in1}
                   + {1'b0, data_valid_in2 &  action_valid_in2};
        n_misses   = {1'b0, data_valid_in1 & ~action_valid_in1}
                   + {1'b0, data_valid_in2 & ~action_valid_in2};
        pop        = (fifo_count != '0) && out_ready;
    end

    // Entry storage: lane 1 lands at wr_ptr, lane 2 right after whatever lane 1 took.
    // NOTE: the memory has no reset; entries are only observable once counted in fifo_count.
    always_ff @(posedge clk) begin
        if (acc1) mem[wr_ptr]   <= {1'b0, action_valid_in1, rule_id1};
        if (acc2) mem[wr_addr2] <= {1'b1, action_valid_in2, rule_id2};
    end

    // Pointers and occupancy; an asynchronous reset empties the FIFO at once.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(n_accepted);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(n_accepted) - CW'(pop);
        end
    end

    // Statistics: every valid lane result counts, stored or dropped; clear wins.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            hit_count       <= '0;
            miss_count      <= '0;
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else if (clr_stats) begin
            hit_count       <= '0;
            miss_count      <= '0;
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            hit_count  <= sat_add(hit_count,  n_hits);
            miss_count <= sat_add(miss_count, n_misses);
            drop_count <= sat_add(drop_count, n_drops);
            if (n_drops != 2'd0) overflow_sticky <= 1'b1;
        end
    end

    // Show-ahead head entry, forced to zero while empty so reset shows all zeros.
    always_comb begin
        head        = mem[rd_ptr];
        out_valid   = (fifo_count != '0);
        out_rule_id = out_valid ? head[RULE_ID-1:0] : '0;
        out_hit     = out_valid & head[RULE_ID];
        out_lane    = out_valid & head[RULE_ID+1];
    end

endmodule

// File: tb/tb_match_result_collector.sv
// Directed self-checking bench for match_result_collector.
// A second instance with 4-bit counters shares all inputs and is used only
// to observe counter saturation.

module tb_match_result_collector;

    localparam int RULE_ID = 14;
    localparam int DEPTH   = 16;

    logic                 clk = 1'b0;
    logic                 RSTn;
    logic [RULE_ID-1:0]   rule_id1, rule_id2;
    logic                 data_valid_in1, data_valid_in2;
    logic                 action_valid_in1, action_valid_in2;
    logic                 out_ready;
    logic                 clr_stats;

    logic [RULE_ID-1:0]   out_rule_id;
    logic                 out_hit, out_lane, out_valid;
    logic [4:0]           fifo_count;
    logic                 overflow_sticky;
    logic [31:0]          hit_count, miss_count, drop_count;

    logic [RULE_ID-1:0]   s_out_rule_id;
    logic                 s_out_hit, s_out_lane, s_out_valid;
    logic [4:0]           s_fifo_count;
    logic                 s_overflow_sticky;
    logic [3:0]           s_hit_count, s_miss_count, s_drop_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    match_result_collector #(.RULE_ID(RULE_ID), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
        .clk(clk), .RSTn(RSTn),
        .rule_id1(rule_id1), .rule_id2(rule_id2),
        .data_valid_in1(data_valid_in1), .data_valid_in2(data_valid_in2),
        .action_valid_in1(action_valid_in1), .action_valid_in2(action_valid_in2),
        .out_rule_id(out_rule_id), .out_hit(out_hit), .out_lane(out_lane),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .overflow_sticky(overflow_sticky), .clr_stats(clr_stats),
        .hit_count(hit_count), .miss_count(miss_count), .drop_count(drop_count)
    );

    match_result_collector #(.RULE_ID(RULE_ID), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .RSTn(RSTn),
        .rule_id1(rule_id1), .rule_id2(rule_id2),
        .data_valid_in1(data_valid_in1), .data_valid_in2(data_valid_in2),
        .action_valid_in1(action_valid_in1), .action_valid_in2(action_valid_in2),
        .out_rule_id(s_out_rule_id), .out_hit(s_out_hit), .out_lane(s_out_lane),
        .out_valid(s_out_valid), .out_ready(out_ready), .fifo_count(s_fifo_count),
        .overflow_sticky(s_overflow_sticky), .clr_stats(clr_stats),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .drop_count(s_drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic d1, input logic a1, input logic [RULE_ID-1:0] i1,
                         input logic d2, input logic a2, input logic [RULE_ID-1:0] i2);
        data_valid_in1   = d1;
        action_valid_in1 = a1;
        rule_id1         = i1;
        data_valid_in2   = d2;
        action_valid_in2 = a2;
        rule_id2         = i2;
    endtask

    task automatic check_head(input string tag, input logic [RULE_ID-1:0] id,
                              input logic lane, input logic hit);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_id"},    32'(out_rule_id), 32'(id));
        check({tag, "_lane"},  32'(out_lane), 32'(lane));
        check({tag, "_hit"},   32'(out_hit), 32'(hit));
    endtask

    initial begin
        // ---- Reset with random inputs ----
        RSTn      = 1'b0;
        out_ready = 1'($urandom);
        clr_stats = 1'($urandom);
        lanes(1'($urandom), 1'($urandom), RULE_ID'($urandom),
              1'($urandom), 1'($urandom), RULE_ID'($urandom));
        tick();
        tick();
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_count",  32'(fifo_count), 32'd0);
        check("rst_id",     32'(out_rule_id), 32'd0);
        check("rst_hit",    32'(out_hit), 32'd0);
        check("rst_lane",   32'(out_lane), 32'd0);
        check("rst_hits",   hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        check("rst_drops",  drop_count, 32'd0);
        check("rst_sticky", 32'(overflow_sticky), 32'd0);

        // ---- First result: one-cycle latency ----
        RSTn      = 1'b1;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        lanes(1'b1, 1'b1, 14'h0123, 1'b0, 1'b0, 14'h0);
        tick();
        check_head("first", 14'h0123, 1'b0, 1'b1);
        check("first_hits",  hit_count, 32'd1);
        check("first_count", 32'(fifo_count), 32'd1);

        // action_valid without data_valid is ignored; pop the entry
        lanes(1'b0, 1'b1, 14'h0055, 1'b0, 1'b1, 14'h0066);
        out_ready = 1'b1;
        tick();
        check("pop1_count", 32'(fifo_count), 32'd0);
        check("pop1_valid", 32'(out_valid), 32'd0);
        check("ign_hits",   hit_count, 32'd1);

        // ---- Clear statistics ----
        lanes(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_hits", hit_count, 32'd0);

        // ---- Dual write ordering ----
        lanes(1'b1, 1'b0, 14'h0005, 1'b1, 1'b1, 14'h0007);
        out_ready = 1'b1;
        tick();
        check("dual_count", 32'(fifo_count), 32'd2);
        check_head("dual_a", 14'h0005, 1'b0, 1'b0);
        check("dual_miss", miss_count, 32'd1);
        check("dual_hit",  hit_count, 32'd1);
        lanes(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        tick();
        check("dual_count2", 32'(fifo_count), 32'd1);
        check_head("dual_b", 14'h0007, 1'b1, 1'b1);
        tick();
        check("dual_empty", 32'(out_valid), 32'd0);

        // ---- Overflow ----
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lanes(1'b1, 1'b0, RULE_ID'(14'h100 + i), 1'b1, 1'b0, RULE_ID'(14'h200 + i));
            tick();
        end
        check("fill_count",  32'(fifo_count), 32'd16);
        check("fill_drops",  drop_count, 32'd0);
        check("fill_sticky", 32'(overflow_sticky), 32'd0);
        lanes(1'b1, 1'b0, 14'h3AA, 1'b1, 1'b0, 14'h3BB);
        tick();
        check("ovf_count",  32'(fifo_count), 32'd16);
        check("ovf_drops",  drop_count, 32'd2);
        check("ovf_sticky", 32'(overflow_sticky), 32'd1);
        check("ovf_misses", miss_count, 32'd18);
        check_head("ovf_head", 14'h0100, 1'b0, 1'b0);

        // pop one, leaving 15 stored
        lanes(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        out_ready = 1'b1;
        tick();
        check("p15_count", 32'(fifo_count), 32'd15);
        check_head("p15_head", 14'h0200, 1'b1, 1'b0);
        // dual write with one free slot: lane 1 stored, lane 2 dropped
        out_ready = 1'b0;
        lanes(1'b1, 1'b0, 14'h0300, 1'b1, 1'b0, 14'h0301);
        tick();
        check("one_slot_count", 32'(fifo_count), 32'd16);
        check("one_slot_drops", drop_count, 32'd3);

        // ---- Full with simultaneous pop ----
        out_ready = 1'b1;
        lanes(1'b1, 1'b0, 14'h03FF, 1'b0, 1'b0, 14'h0);
        tick();
        check("fullpop_count", 32'(fifo_count), 32'd15);
        check("fullpop_drops", drop_count, 32'd4);
        check_head("fullpop_head", 14'h0101, 1'b0, 1'b0);

        // drain: the last entry is the lane-1 survivor of the one-slot write
        lanes(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        for (int i = 0; i < 14; i++) tick();
        check("drain_count1", 32'(fifo_count), 32'd1);
        check_head("drain_last", 14'h0300, 1'b0, 1'b0);
        tick();
        check("drain_count0", 32'(fifo_count), 32'd0);
        check("drain_sticky", 32'(overflow_sticky), 32'd1);

        // ---- Wrap-around stream ----
        out_ready = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            lanes(1'b1, 1'b0, RULE_ID'(k), 1'b0, 1'b0, 14'h0);
            tick();
            check($sformatf("wrap_id_%0d", k), 32'(out_rule_id), 32'(k));
            check($sformatf("wrap_cnt_%0d", k), 32'(fifo_count), 32'd1);
        end
        lanes(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        tick();
        check("wrap_empty", 32'(fifo_count), 32'd0);

        // ---- clr_stats coincident with a hit ----
        clr_stats = 1'b1;
        lanes(1'b1, 1'b1, 14'h0001, 1'b0, 1'b0, 14'h0);
        tick();
        clr_stats = 1'b0;
        check("clrhit_hits",   hit_count, 32'd0);
        check("clrhit_drops",  drop_count, 32'd0);
        check("clrhit_sticky", 32'(overflow_sticky), 32'd0);
        check("clrhit_shits",  32'(s_hit_count), 32'd0);
        check("clrhit_fifo",   32'(fifo_count), 32'd1);

        // ---- Saturation on the 4-bit instance ----
        for (int i = 0; i < 20; i++) begin
            lanes(1'b1, 1'b1, RULE_ID'(i + 1), 1'b0, 1'b0, 14'h0);
            tick();
        end
        check("sat_small", 32'(s_hit_count), 32'd15);
        check("sat_wide",  hit_count, 32'd20);
        check("sat_small_miss", 32'(s_miss_count), 32'd0);

        // ---- Asynchronous reset mid-operation ----
        out_ready = 1'b0;
        lanes(1'b1, 1'b1, 14'h0AAA, 1'b1, 1'b0, 14'h0BBB);
        tick();
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        lanes(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        #2;
        RSTn = 1'b0;
        #1;
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_drops", drop_count, 32'd0);
        tick();
        RSTn = 1'b1;
        tick();
        check("post_rst_count", 32'(fifo_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
